i2c_slave_ctrl: RTL and testbench
=================================

# i2c_slave_ctrl

Sequencing controller for the I2C slave datapath. It runs on one system clock and oversamples the raw SCL/SDA lines. It detects START/STOP conditions, walks the transaction phases using the slave state encoding, counts bits, and matches the 7-bit address. It drives the open-drain SDA pull-down and hands received and transmitted bytes to the local host through single-cycle strobes.

## Interface
Parameters:
- SLAVE_ADDR, 7'b1001011, 7-bit address this slave answers to
- SYNC_STAGES, 2, synchronizer depth on scl_in/sda_in (≥2)

Ports:
- clk  in  1  system clock; must run at ≥16× the SCL frequency
- rst  in  1  reset, synchronous, active-high
- scl_in  in  1  raw bus SCL
- sda_in  in  1  raw bus SDA
- sda_oe  out  1  1 = pull SDA low; 0 = release
- state  out  3  phase: idle=0, start=1, address=3, acknowledge1=2, data=6, acknowledge2=7, stop=5
- master_read  out  1  R/W bit of the current matched transaction (1 = master reads)
- addr_match  out  1  high from acknowledge1 entry until idle/start
- tx_data  in  8  byte to transmit on reads; must be stable when tx_load pulses
- tx_load  out  1  1-cycle pulse when tx_data is latched into the shift register
- rx_data  out  8  last byte received on a write
- rx_valid  out  1  1-cycle pulse; rx_data is valid in the same cycle
- nack_seen  out  1  1-cycle pulse when the master NACKs a read byte
- busy  out  1  high whenever state ≠ idle

## Operation
- Synchronize scl_in and sda_in through SYNC_STAGES flops, then one history flop each. Synchronizer and history flops reset to 1 (idle bus).
- Edge decodes:
  - scl_rise / scl_fall: SCL edges.
  - start_det: SCL high and SDA 1→0.
  - stop_det: SCL high and SDA 0→1.
- Priority in any cycle: rst > stop_det > start_det > SCL edges.
- stop_det in any state except idle → stop.
- start_det in any state (repeated start) → start.
  - On either, release sda_oe, clear the bit counter and discard any partial byte (no rx_valid).
- State transitions:
  - idle: start_det → start. No other event has any effect.
  - start: scl_fall → address, bitcnt=0.
  - address: each scl_rise shifts SDA into an 8-bit shift register, MSB first, bitcnt++. On the scl_fall after the 8th rise:
    - if shreg[7:1]==SLAVE_ADDR: → acknowledge1, sda_oe=1, master_read=shreg[0], addr_match=1.
    - else: → idle; the slave ignores the bus until the next start_det.
  - acknowledge1: holds sda_oe=1 through the ACK clock. On the next scl_fall → data, bitcnt=0.
    - write: sda_oe=0.
    - read: latch tx_data, pulse tx_load, sda_oe=~tx_data[7].
  - data, write: each scl_rise shifts SDA in. On the scl_fall after the 8th rise → acknowledge2, sda_oe=1, rx_data=byte, rx_valid pulse.
  - data, read: each scl_fall after bits 1..7 shifts out the next bit (sda_oe=~bit). On the scl_fall after the 8th bit → acknowledge2, sda_oe=0.
  - acknowledge2, write: next scl_fall → data, sda_oe=0, bitcnt=0. Bytes repeat until STOP or repeated start.
  - acknowledge2, read: sample SDA on scl_rise.
    - SDA=0 (ACK): next scl_fall reloads tx_data (tx_load pulse), drives bit 7, → data.
    - SDA=1 (NACK): nack_seen pulses, sda_oe stays 0, the slave waits for stop/start; further SCL edges are ignored.
  - stop: exactly one cycle, then idle. addr_match=0, master_read=0.
- Bit counter is 4 bits wide and saturates at 8; no wrap inside a byte.

## Timing
- Reset values: state=0, sda_oe=0, master_read=0, addr_match=0, tx_load=0, rx_data=8'h00, rx_valid=0, nack_seen=0, busy=0.
- All outputs are registered.
- Raw pin edge → decoded event: SYNC_STAGES+1 clk (3 with the default).
- Decoded event → state/sda_oe update: 1 clk.
- sda_oe therefore changes 4 clk after the raw SCL fall. This is well inside the SCL low time given the 16× ratio.
- rx_valid and the acknowledge2 entry happen in the same cycle.
- tx_load fires in the cycle the acknowledge→data transition registers.
- Reset during a transaction: outputs take reset values on the next clk edge, SDA is released, and no strobes are emitted.

## Test plan
- Write transaction: START, address 0x4B+W, data 0xA5, STOP.
  - SDA is pulled low during both 9th clocks.
  - rx_valid pulses once with rx_data=0xA5.
  - state sequence is 0,1,3,2,6,7,6,5,0.
- Address mismatch: START, 0x4A+W, byte 0xFF.
  - sda_oe never asserts.
  - state returns to 0 after the 8th address bit.
  - rx_valid never asserts.
- Read transaction: 0x4B+R with tx_data=0x3C, then 0xC3 after the master ACK, then master NACK, then STOP.
  - Bus carries 0x3C and 0xC3.
  - tx_load pulses twice.
  - nack_seen pulses once.
  - state ends at 0.
- Repeated start after 4 data bits of a write.
  - state=1 and sda_oe=0 within 4 clk.
  - No rx_valid.
  - The following 0x4B+R transaction completes normally.
- rst asserted for 1 clk while sda_oe=1 in acknowledge1.
  - Next cycle: all outputs at reset values.
  - No false start_det after rst deasserts with SDA/SCL high.

Source files
------------

// File: rtl/i2c_slave_ctrl.sv
// i2c_slave_ctrl -- sequencing controller for the I2C slave datapath.
// Oversamples SCL/SDA on clk, detects START/STOP, walks the transaction
// phases, matches the 7-bit address and drives the open-drain SDA pull-down.
//
// Ports:
//   clk, rst     system clock (>=16x SCL), synchronous active-high reset
//   scl_in       raw bus SCL
//   sda_in       raw bus SDA
//   sda_oe       1 = pull SDA low, 0 = release
//   state        phase code: idle=0 start=1 ack1=2 address=3 stop=5 data=6 ack2=7
//   master_read  R/W bit of the current matched transaction
//   addr_match   high from acknowledge1 entry until idle/start
//   tx_data      byte to send on reads, latched when tx_load pulses
//   tx_load      1-cycle pulse when tx_data is captured
//   rx_data      last byte received on a write
//   rx_valid     1-cycle pulse, rx_data valid in the same cycle
//   nack_seen    1-cycle pulse when the master NACKs a read byte
//   busy         high whenever state != idle
module i2c_slave_ctrl #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'b1001011,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [2:0] state,
  output logic       master_read,
  output logic       addr_match,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       nack_seen,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ACK1  = 3'd2,
    ST_ADDR  = 3'd3,
    ST_STOP  = 3'd5,
    ST_DATA  = 3'd6,
    ST_ACK2  = 3'd7
  } state_t;

  state_t state_q, state_nxt;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_hist, sda_hist;
  logic                   scl_s, sda_s;
  logic                   scl_rise_q, scl_fall_q, start_q, stop_q;

  logic [3:0] bitcnt_q, bitcnt_n, bitcnt_inc;
  logic [7:0] shreg_q, shreg_n;
  logic       ack_smp_q, ack_smp_n;   // master ACK bit sampled in ack2 (read)
  logic       ack_nak_q, ack_nak_n;   // sampled value was NACK
  logic       sda_oe_n, master_read_n, addr_match_n;
  logic       tx_load_n, rx_valid_n, nack_seen_n;
  logic [7:0] rx_data_n;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
  assign state = state_q;

  // Synchronizers and history flops idle high so reset never fakes a START.
  // Decoded events are registered, giving SYNC_STAGES+1 clk pin-to-event.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync   <= '1;
      sda_sync   <= '1;
      scl_hist   <= 1'b1;
      sda_hist   <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync   <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync   <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_hist   <= scl_s;
      sda_hist   <= sda_s;
      scl_rise_q <= scl_s & ~scl_hist;
      scl_fall_q <= ~scl_s & scl_hist;
      start_q    <= scl_s & scl_hist & sda_hist & ~sda_s;
      stop_q     <= scl_s & scl_hist & ~sda_hist & sda_s;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    if (stop_q) begin
      if (state_q != ST_IDLE) state_nxt = ST_STOP;
    end else if (start_q) begin
      state_nxt = ST_START;
    end else begin
      case (state_q)
        ST_START: if (scl_fall_q) state_nxt = ST_ADDR;
        ST_ADDR:
          if (scl_fall_q && bitcnt_q == 4'd8)
            state_nxt = (shreg_q[7:1] == SLAVE_ADDR) ? ST_ACK1 : ST_IDLE;
        ST_ACK1:  if (scl_fall_q) state_nxt = ST_DATA;
        ST_DATA:  if (scl_fall_q && bitcnt_q == 4'd8) state_nxt = ST_ACK2;
        ST_ACK2:
          if (scl_fall_q && (!master_read || (ack_smp_q && !ack_nak_q)))
            state_nxt = ST_DATA;
        ST_STOP:  state_nxt = ST_IDLE;
        default:  state_nxt = state_q;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    bitcnt_n      = bitcnt_q;
    shreg_n       = shreg_q;
    ack_smp_n     = ack_smp_q;
    ack_nak_n     = ack_nak_q;
    sda_oe_n      = sda_oe;
    master_read_n = master_read;
    addr_match_n  = addr_match;
    rx_data_n     = rx_data;
    tx_load_n     = 1'b0;
    rx_valid_n    = 1'b0;
    nack_seen_n   = 1'b0;
    bitcnt_inc    = (bitcnt_q == 4'd8) ? bitcnt_q : bitcnt_q + 4'd1;

    if ((stop_q && state_q != ST_IDLE) || start_q) begin
      sda_oe_n      = 1'b0;
      bitcnt_n      = '0;
      shreg_n       = '0;
      ack_smp_n     = 1'b0;
      ack_nak_n     = 1'b0;
      master_read_n = 1'b0;
      addr_match_n  = 1'b0;
    end else begin
      case (state_q)
        ST_START: if (scl_fall_q) bitcnt_n = '0;
        ST_ADDR: begin
          if (scl_rise_q) begin
            shreg_n  = {shreg_q[6:0], sda_s};
            bitcnt_n = bitcnt_inc;
          end else if (scl_fall_q && bitcnt_q == 4'd8 &&
                       shreg_q[7:1] == SLAVE_ADDR) begin
            sda_oe_n      = 1'b1;
            master_read_n = shreg_q[0];
            addr_match_n  = 1'b1;
          end
        end
        ST_ACK1: begin
          if (scl_fall_q) begin
            bitcnt_n = '0;
            if (master_read) begin
              shreg_n   = tx_data;
              tx_load_n = 1'b1;
              sda_oe_n  = ~tx_data[7];
            end else begin
              sda_oe_n  = 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (scl_rise_q) begin
            bitcnt_n = bitcnt_inc;
            if (!master_read) shreg_n = {shreg_q[6:0], sda_s};
          end else if (scl_fall_q) begin
            if (bitcnt_q == 4'd8) begin
              ack_smp_n = 1'b0;
              ack_nak_n = 1'b0;
              if (master_read) begin
                sda_oe_n   = 1'b0;
              end else begin
                sda_oe_n   = 1'b1;
                rx_data_n  = shreg_q;
                rx_valid_n = 1'b1;
              end
            end else if (master_read) begin
              // shreg[7] is already on the bus; move the next bit up
              shreg_n  = {shreg_q[6:0], 1'b0};
              sda_oe_n = ~shreg_q[6];
            end
          end
        end
        ST_ACK2: begin
          if (!master_read) begin
            if (scl_fall_q) begin
              sda_oe_n = 1'b0;
              bitcnt_n = '0;
            end
          end else if (scl_rise_q && !ack_smp_q) begin
            ack_smp_n   = 1'b1;
            ack_nak_n   = sda_s;
            nack_seen_n = sda_s;
          end else if (scl_fall_q && ack_smp_q && !ack_nak_q) begin
            bitcnt_n  = '0;
            shreg_n   = tx_data;
            tx_load_n = 1'b1;
            sda_oe_n  = ~tx_data[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      ack_smp_q   <= 1'b0;
      ack_nak_q   <= 1'b0;
      sda_oe      <= 1'b0;
      master_read <= 1'b0;
      addr_match  <= 1'b0;
      tx_load     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      nack_seen   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      bitcnt_q    <= bitcnt_n;
      shreg_q     <= shreg_n;
      ack_smp_q   <= ack_smp_n;
      ack_nak_q   <= ack_nak_n;
      sda_oe      <= sda_oe_n;
      master_read <= master_read_n;
      addr_match  <= addr_match_n;
      tx_load     <= tx_load_n;
      rx_data     <= rx_data_n;
      rx_valid    <= rx_valid_n;
      nack_seen   <= nack_seen_n;
      busy        <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
module tb_i2c_slave_ctrl;

  localparam logic [6:0] SADDR = 7'h4B;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [2:0] state;
  logic       master_read, addr_match;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load;
  logic [7:0] rx_data;
  logic       rx_valid, nack_seen, busy;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_ctrl #(.SLAVE_ADDR(SADDR), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .scl_in      (scl_m),
    .sda_in      (sda_bus),
    .sda_oe      (sda_oe),
    .state       (state),
    .master_read (master_read),
    .addr_match  (addr_match),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .nack_seen   (nack_seen),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Bus-side observation log
  logic [7:0]  rx_log[$];
  logic [2:0]  st_log[$];
  logic [2:0]  last_state = 3'd0;
  int unsigned n_txload = 0, n_nack = 0, n_oe = 0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_log.push_back(rx_data);
    if (tx_load === 1'b1) n_txload++;
    if (nack_seen === 1'b1) n_nack++;
    if (sda_oe === 1'b1) n_oe++;
    if (state !== last_state) begin
      st_log.push_back(state);
      last_state = state;
    end
  end

  int unsigned n_pass = 0, n_total = 0;
  logic [7:0]  txn_bytes[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clks(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // SCL half period is 10 clk; SDA moves only mid-way through SCL low.
  task automatic bus_start();
    sda_m = 1'b0; clks(10); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    clks(5); sda_m = 1'b0; clks(5); scl_m = 1'b1; clks(10); sda_m = 1'b1; clks(20);
  endtask

  task automatic put_bit(input logic b);
    clks(5); sda_m = b; clks(5); scl_m = 1'b1; clks(10); scl_m = 1'b0;
  endtask

  task automatic get_bit(output logic b);
    clks(5); sda_m = 1'b1; clks(5); scl_m = 1'b1; clks(5); b = sda_bus; clks(5); scl_m = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] v);
    for (int unsigned i = 0; i < 8; i++) put_bit(v[7-i]);
  endtask

  task automatic get_byte(output logic [7:0] v);
    logic b;
    v = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      get_bit(b);
      v[7-i] = b;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " state"},       32'(state),       32'd0);
    chk({tag, " sda_oe"},      32'(sda_oe),      32'd0);
    chk({tag, " master_read"}, 32'(master_read), 32'd0);
    chk({tag, " addr_match"},  32'(addr_match),  32'd0);
    chk({tag, " tx_load"},     32'(tx_load),     32'd0);
    chk({tag, " rx_data"},     32'(rx_data),     32'd0);
    chk({tag, " rx_valid"},    32'(rx_valid),    32'd0);
    chk({tag, " nack_seen"},   32'(nack_seen),   32'd0);
    chk({tag, " busy"},        32'(busy),        32'd0);
  endtask

  // One complete START..STOP transaction; expected behaviour comes from the
  // protocol rules: who ACKs, which bytes arrive, how many loads/NACKs, and
  // the phase sequence the slave should walk.
  task automatic run_txn(input string tag, input logic [6:0] a, input logic rw,
                         input int unsigned nb);
    logic        b, match;
    logic [7:0]  got;
    logic [2:0]  exp_st[$];
    int unsigned rx0, tl0, nk0, oe0, st0, exp_rx;
    match = (a == SADDR);
    rx0 = rx_log.size(); tl0 = n_txload; nk0 = n_nack; oe0 = n_oe; st0 = st_log.size();

    exp_st.push_back(3'd1);
    exp_st.push_back(3'd3);
    if (!match) begin
      exp_st.push_back(3'd0);
    end else begin
      exp_st.push_back(3'd2);
      for (int unsigned i = 0; i < nb; i++) begin
        exp_st.push_back(3'd6);
        exp_st.push_back(3'd7);
      end
      if (!rw) exp_st.push_back(3'd6);
      exp_st.push_back(3'd5);
      exp_st.push_back(3'd0);
    end

    if (rw) tx_data = txn_bytes[0];
    bus_start();
    put_byte({a, rw});
    get_bit(b);
    chk({tag, " addr ack"}, 32'(b), 32'(!match));
    if (!rw) begin
      for (int unsigned i = 0; i < nb; i++) begin
        put_byte(txn_bytes[i]);
        get_bit(b);
        chk({tag, " data ack"}, 32'(b), 32'(!match));
      end
    end else if (match) begin
      for (int unsigned i = 0; i < nb; i++) begin
        get_byte(got);
        chk({tag, " read byte"}, 32'(got), 32'(txn_bytes[i]));
        if (i + 1 < nb) tx_data = txn_bytes[i+1];
        put_bit(i + 1 == nb);
      end
    end
    bus_stop();

    exp_rx = (match && !rw) ? nb : 0;
    chk({tag, " rx count"}, rx_log.size() - rx0, exp_rx);
    for (int unsigned i = 0; i < exp_rx && rx0 + i < rx_log.size(); i++)
      chk({tag, " rx byte"}, 32'(rx_log[rx0+i]), 32'(txn_bytes[i]));
    chk({tag, " tx_load count"}, n_txload - tl0, (match && rw) ? nb : 0);
    chk({tag, " nack count"}, n_nack - nk0, (match && rw) ? 1 : 0);
    if (!match) chk({tag, " sda_oe cycles"}, n_oe - oe0, 0);
    chk({tag, " final state"}, 32'(state), 32'd0);
    chk({tag, " final busy"}, 32'(busy), 32'd0);
    chk({tag, " phase count"}, st_log.size() - st0, exp_st.size());
    for (int unsigned i = 0; i < exp_st.size() && st0 + i < st_log.size(); i++)
      chk({tag, " phase"}, 32'(st_log[st0+i]), 32'(exp_st[i]));
  endtask

  initial begin
    logic        b;
    logic [7:0]  got, rbyte;
    logic [6:0]  ra;
    int unsigned rx0, tl0, nk0;

    clks(5);
    chk_reset_outputs("reset");
    rst = 1'b0;
    clks(10);

    txn_bytes[0] = 8'hA5;
    run_txn("write", SADDR, 1'b0, 1);

    txn_bytes[0] = 8'hFF;
    run_txn("mismatch", 7'h4A, 1'b0, 1);

    txn_bytes[0] = 8'h3C;
    txn_bytes[1] = 8'hC3;
    run_txn("read", SADDR, 1'b1, 2);

    // Repeated START four bits into a write byte
    rx0 = rx_log.size(); tl0 = n_txload; nk0 = n_nack;
    bus_start();
    put_byte({SADDR, 1'b0});
    get_bit(b);
    chk("rstart addr ack", 32'(b), 32'd0);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
    clks(5); sda_m = 1'b1; clks(5); scl_m = 1'b1; clks(10); sda_m = 1'b0;
    clks(4);
    chk("rstart state", 32'(state), 32'd1);
    chk("rstart sda_oe", 32'(sda_oe), 32'd0);
    clks(6); scl_m = 1'b0;
    rbyte = 8'($urandom_range(0, 255));
    tx_data = rbyte;
    put_byte({SADDR, 1'b1});
    get_bit(b);
    chk("rstart read ack", 32'(b), 32'd0);
    get_byte(got);
    chk("rstart read byte", 32'(got), 32'(rbyte));
    put_bit(1'b1);
    bus_stop();
    chk("rstart rx count", rx_log.size() - rx0, 0);
    chk("rstart tx_load count", n_txload - tl0, 1);
    chk("rstart nack count", n_nack - nk0, 1);
    chk("rstart final state", 32'(state), 32'd0);

    // Reset while the slave is driving the address ACK
    bus_start();
    put_byte({SADDR, 1'b0});
    clks(5);
    chk("ack1 sda_oe", 32'(sda_oe), 32'd1);
    chk("ack1 state", 32'(state), 32'd2);
    chk("ack1 addr_match", 32'(addr_match), 32'd1);
    rx0 = rx_log.size(); tl0 = n_txload; nk0 = n_nack;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    clks(1);
    rst = 1'b0;
    chk_reset_outputs("midrst");
    clks(30);
    chk("midrst idle state", 32'(state), 32'd0);
    chk("midrst idle busy", 32'(busy), 32'd0);
    chk("midrst strobes", (rx_log.size() - rx0) + (n_txload - tl0) + (n_nack - nk0), 0);

    // Randomized transactions
    for (int unsigned t = 0; t < 8; t++) begin
      ra = SADDR;
      if ($urandom_range(0, 3) == 0) begin
        ra = 7'($urandom_range(0, 127));
        if (ra == SADDR) ra = ra ^ 7'h01;
      end
      for (int unsigned i = 0; i < 4; i++) txn_bytes[i] = 8'($urandom_range(0, 255));
      run_txn("random", ra, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
